// File: rtl/traffic_pkg.sv
// Shared traffic-light types: light colour encodings and the car sensor
// filter state encoding.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    REQ  = 2'd2,
    HOLD = 2'd3
  } filt_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, cleared by the
// asynchronous active-low clear_n.
module sync_2ff (
  input  logic clk,
  input  logic clear_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two register stages to resolve metastability before the level is used
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/car_sensor_filter.sv
// Country-road car sensor filter: synchronizes and debounces the loop
// detector, raises x (car waiting) until the country light is served, then
// holds off until the car has clearly left.
// Optional build macro CAR_SENSOR_STAT_EN adds the saturating req_count port.
module car_sensor_filter
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       sensor_raw,
  input  logic       served,
  output logic       x
`ifdef CAR_SENSOR_STAT_EN
  ,
  output logic [7:0] req_count
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  filt_state_t state;
  logic [7:0]  cnt;
  logic        s;

  sync_2ff u_sync (
    .clk     (clk),
    .clear_n (clear_n),
    .d       (sensor_raw),
    .q       (s)
  );

  // Debounce/request FSM; x is registered alongside state so it always equals (state == REQ)
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= IDLE;
      cnt   <= '0;
      x     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state <= QUAL;
            cnt   <= 8'd1;
          end else begin
            cnt   <= '0;
          end
        end
        QUAL: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= REQ;
            cnt   <= '0;
            x     <= 1'b1;
          end else begin
            cnt   <= cnt + 8'd1;
          end
        end
        REQ: begin
          // served wins over any sensor change in this state
          if (served) begin
            state <= HOLD;
            cnt   <= '0;
            x     <= 1'b0;
          end
        end
        HOLD: begin
          // a car still present restarts the leave-detection count
          if (s) begin
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          x     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAR_SENSOR_STAT_EN
  // Saturating count of QUAL->REQ transitions, cleared only by reset
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      req_count <= '0;
    end else if (state == QUAL && s && cnt == CNT_LAST && req_count != 8'hFF) begin
      req_count <= req_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_car_sensor_filter.sv
// Directed self-checking bench for car_sensor_filter (DEBOUNCE_CYCLES = 4).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
module tb_car_sensor_filter;
  import traffic_pkg::*;

  localparam int unsigned DEB = 4;

  logic clk = 1'b0;
  logic clear_n;
  logic sensor_raw;
  logic served;
  logic x;
`ifdef CAR_SENSOR_STAT_EN
  logic [7:0] req_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_req  = 0;

  always #5 clk = ~clk;

  car_sensor_filter #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .sensor_raw (sensor_raw),
    .served     (served),
    .x          (x)
`ifdef CAR_SENSOR_STAT_EN
    ,
    .req_count  (req_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag);
`ifdef CAR_SENSOR_STAT_EN
    check(tag, 32'(req_count), 32'(exp_req));
`else
    exp_req = exp_req;
`endif
  endtask

  // From IDLE with quiet synchronizer: press and expect x after exactly 6 edges
  task automatic press_to_req(input string tag);
    sensor_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check({tag, "_x_low"}, 32'(x), 32'd0);
    end
    tick();
    check({tag, "_x_high"}, 32'(x), 32'd1);
    if (exp_req < 255) exp_req++;
    check_count({tag, "_cnt"});
  endtask

  // Serve for one cycle, then let the car leave; HOLD lasts until 6th edge
  task automatic serve_and_leave(input string tag);
    served = 1'b1;
    tick();
    check({tag, "_x_served"}, 32'(x), 32'd0);
    served     = 1'b0;
    sensor_raw = 1'b0;
    repeat (5) tick();
    check({tag, "_still_hold"}, 32'(dut.state), 32'(HOLD));
    tick();
    check({tag, "_idle"}, 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    clear_n    = 1'b0;
    sensor_raw = 1'b0;
    served     = 1'b0;
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_cnt", 32'(dut.cnt), 32'd0);
    check_count("rst_reqcnt");
    #12 clear_n = 1'b1;

    // Basic latency, x holds while not served
    press_to_req("lat");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_x", 32'(x), 32'd1);
    end

    // One-cycle serve with sensor high; same car cannot retrigger
    served = 1'b1;
    tick();
    check("serve_x", 32'(x), 32'd0);
    served = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("noretrig_x", 32'(x), 32'd0);
    end
    sensor_raw = 1'b0;
    repeat (5) tick();
    check("leave_hold", 32'(dut.state), 32'(HOLD));
    tick();
    check("leave_idle", 32'(dut.state), 32'(IDLE));
    press_to_req("rearm");
    serve_and_leave("rearm");

    // Short 3-cycle pulse reaches the top of the count but never requests
    sensor_raw = 1'b1;
    repeat (3) tick();
    sensor_raw = 1'b0;
    check("pulse_x0", 32'(x), 32'd0);
    repeat (2) tick();
    check("pulse_state_top", 32'(dut.state), 32'(QUAL));
    check("pulse_cnt_top", 32'(dut.cnt), 32'(DEB - 1));
    tick();
    check("pulse_state_idle", 32'(dut.state), 32'(IDLE));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("pulse_x", 32'(x), 32'd0);
    end
    check("pulse_cnt", 32'(dut.cnt), 32'd0);

    // Reset mid-QUAL, asynchronous and clock-free
    sensor_raw = 1'b1;
    repeat (4) tick();
    check("midq_state", 32'(dut.state), 32'(QUAL));
    clear_n = 1'b0;
    #1;
    exp_req = 0;
    check("midq_rst_x", 32'(x), 32'd0);
    check("midq_rst_state", 32'(dut.state), 32'(IDLE));
    check("midq_rst_cnt", 32'(dut.cnt), 32'd0);
    check_count("midq_rst_reqcnt");
    #1 clear_n = 1'b1;
    press_to_req("afterq");

    // Reset mid-REQ
    repeat (2) tick();
    check("midr_x_before", 32'(x), 32'd1);
    clear_n = 1'b0;
    #1;
    exp_req = 0;
    check("midr_rst_x", 32'(x), 32'd0);
    check("midr_rst_state", 32'(dut.state), 32'(IDLE));
    check_count("midr_rst_reqcnt");
    #1 clear_n = 1'b1;
    press_to_req("afterr");
    serve_and_leave("afterr");

    // served held high through IDLE/QUAL is ignored
    served     = 1'b1;
    sensor_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("srvidle_x_low", 32'(x), 32'd0);
    end
    tick();
    check("srvidle_x_high", 32'(x), 32'd1);
    if (exp_req < 255) exp_req++;
    tick();
    check("srvidle_x_fall", 32'(x), 32'd0);
    check("srvidle_hold", 32'(dut.state), 32'(HOLD));
    served     = 1'b0;
    sensor_raw = 1'b0;
    repeat (6) tick();
    check("srvidle_idle", 32'(dut.state), 32'(IDLE));

`ifdef CAR_SENSOR_STAT_EN
    // Saturation of the request counter
    clear_n = 1'b0;
    #1;
    exp_req = 0;
    check("sat_rst", 32'(req_count), 32'd0);
    #1 clear_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      press_to_req("sat");
      serve_and_leave("sat");
    end
    check("sat_final", 32'(req_count), 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/car_sensor_filter.md
CAR_SENSOR_FILTER -- requirements
Module: car_sensor_filter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive synchronized-sample count that qualifies a sensor edge (legal 2..255).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 clear_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 sensor_raw  input  1  SHALL be the asynchronous country-road loop detector level, 1 = car present.
REQ-005 served  input  1  SHALL be the synchronous level from the light controller, 1 = country light currently GREEN.
REQ-006 x  output  1  SHALL be the registered, debounced car-waiting request that feeds the light controller's x input.
REQ-007 req_count  output  8  SHALL be the saturating count of requests issued; present only when the configuration macro is defined.

Function
REQ-008 sensor_raw SHALL pass through a 2-flop synchronizer; its output s is the only form of the sensor used internally.
REQ-009 The FSM SHALL have four states: IDLE, QUAL, REQ, HOLD, with an 8-bit counter cnt.
REQ-010 IDLE: s=1 SHALL go to QUAL with cnt=1; otherwise stay, cnt=0.
REQ-011 QUAL: s=0 SHALL return to IDLE with cnt=0; s=1 and cnt=DEBOUNCE_CYCLES-1 SHALL go to REQ; otherwise cnt increments.
REQ-012 REQ: x SHALL be 1 regardless of s; served=1 SHALL go to HOLD with cnt=0; otherwise stay.
REQ-013 HOLD: s=0 SHALL increment cnt, and the transition to IDLE SHALL occur when cnt=DEBOUNCE_CYCLES-1; s=1 SHALL clear cnt and stay, so the same car cannot retrigger.
REQ-014 x SHALL equal (state==REQ), decoded from the state register with no combinational path from any input.
REQ-015 Latency: with sensor_raw stable high from edge 1, x SHALL rise after edge 2+DEBOUNCE_CYCLES.
REQ-016 x SHALL fall after the first edge at which served=1 is sampled in REQ.
REQ-017 served SHALL be ignored in IDLE, QUAL and HOLD.
REQ-018 served=1 and s=0 in the same REQ cycle SHALL go to HOLD; served takes precedence over any sensor change.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.

Reset
REQ-020 While clear_n=0, all of the following SHALL hold immediately, independent of clk: state=IDLE, cnt=0, synchronizer flops=0, x=0, req_count=0.
REQ-021 Reset asserted mid-QUAL, mid-REQ or mid-HOLD SHALL discard the pending request; the first evaluation after deassertion starts from IDLE.

Configuration
REQ-022 With CAR_SENSOR_STAT_EN defined: req_count SHALL increment on every QUAL->REQ transition, saturate at 255, and clear only on reset.
REQ-023 Without CAR_SENSOR_STAT_EN: the req_count port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-024 Shared package traffic_pkg SHALL hold the light encodings RED=0, YELLOW=1, GREEN=2 and the filter state encoding IDLE=0, QUAL=1, REQ=2, HOLD=3.
REQ-025 The synchronizer SHALL be the sub-module sync_2ff (clk, clear_n, d, q), reusable elsewhere.

Verification
REQ-026 DEBOUNCE_CYCLES=4, sensor_raw held 1 from edge 1 -> x=0 through edge 5, x=1 after edge 6, x stays 1 with served=0.
REQ-027 sensor_raw pulse of 3 cycles -> x never asserts; FSM returns to IDLE, cnt=0.
REQ-028 In REQ, served=1 for 1 cycle with sensor high -> x=0 next edge; sensor held high 20 more cycles -> x stays 0; sensor low 4 synchronized cycles then high 4 -> x re-asserts.
REQ-029 clear_n pulsed low mid-QUAL and again mid-REQ -> x=0 and req_count=0 without a clock edge; after release, a clean press again takes 6 edges.
REQ-030 served=1 held throughout IDLE/QUAL -> no effect, x asserts at edge 6; then x falls next edge.
REQ-031 CAR_SENSOR_STAT_EN defined, 300 complete request/serve cycles -> req_count=255; undefined -> compiles without req_count.
